rca_sched: RTL and testbench

Shared-adder scheduler for the ripple-carry adder datapath. Arbitrates NUM_REQ requesters onto one WIDTH-bit adder with round-robin fairness, valid/ready handshakes on every requester and on the result port, and a one-deep registered result stage. Sits between the client blocks and the adder so that one adder instance serves several clients.

---
 rtl/rca_sched_pkg.sv | 18 +
 rtl/rca_sched_rr.sv | 34 +++
 rtl/rca_sched.sv | 112 +++++++++++
 tb/tb_rca_sched.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rca_sched_pkg.sv
// Shared types and constants for the rca_sched shared-adder scheduler.
// Holds the result-stage state enum, default sizes and the id-width helper.
package rca_sched_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_NUM_REQ = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Width of a requester index; clamped to one bit so a lone requester still has an id.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rca_sched_rr.sv
// Round-robin arbiter: first requester at or after ptr (mod N) wins.
// Grant is one-hot and gated by en; idx is the ungated winner index.
module rca_sched_rr #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx
);

    logic           found;
    logic [IDW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        if (en && found) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rca_sched.sv
// Shared-adder scheduler: round-robin onto one adder with a one-deep result stage.
// Optional per-requester carry chaining is enabled by RCA_SCHED_CARRY_CHAIN_EN.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_EMPTY | no result held; any valid requester may transfer
//   ST_FULL  | result held on rsp_*; new transfer only when rsp_ready
module rca_sched
    import rca_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDW    = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    input  logic [NUM_REQ-1:0]       req_chain,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [IDW-1:0]           rsp_id
);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   win_idx;
    logic             slot_free;
    logic             xfer;
    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];
    logic [WIDTH-1:0] a_sel, b_sel;
    logic             cin_sel;
    logic [WIDTH:0]   sum_full;

    assign slot_free = (state_q == ST_EMPTY) || rsp_ready;

    rca_sched_rr #(.N(NUM_REQ), .IDW(IDW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .en    (slot_free && rst_n),
        .grant (req_ready),
        .idx   (win_idx)
    );

    assign xfer      = |req_ready;
    assign rsp_valid = (state_q == ST_FULL);

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = req_a[i*WIDTH +: WIDTH];
            b_arr[i] = req_b[i*WIDTH +: WIDTH];
        end
    end

    assign a_sel = a_arr[win_idx];
    assign b_sel = b_arr[win_idx];

`ifdef RCA_SCHED_CARRY_CHAIN_EN
    logic [NUM_REQ-1:0] carry_q;

    assign cin_sel = req_chain[win_idx] ? carry_q[win_idx] : req_cin[win_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_q <= '0;
        end else if (xfer) begin
            carry_q[win_idx] <= sum_full[WIDTH];
        end
    end
`else
    logic unused_chain;

    assign unused_chain = ^req_chain;
    assign cin_sel      = req_cin[win_idx];
`endif

    // Full-width sum keeps the carry out of the top bit.
    assign sum_full = {1'b0, a_sel} + {1'b0, b_sel} + {{WIDTH{1'b0}}, cin_sel};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (xfer) state_d = ST_FULL;
            ST_FULL:  if (rsp_ready && !xfer) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            ptr_q    <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                {rsp_cout, rsp_sum} <= sum_full;
                rsp_id              <= win_idx;
                ptr_q <= (win_idx == IDW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rca_sched.sv
// Directed self-checking bench for rca_sched (WIDTH=16, NUM_REQ=4).
// Expected chain result follows RCA_SCHED_CARRY_CHAIN_EN when it is defined.
module tb_rca_sched;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic [N-1:0]   req_chain;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic [1:0]     rsp_id;

    int total = 0;
    int bad   = 0;

    rca_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_chain (req_chain),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic chain);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = cin;
        req_chain[i]    = chain;
    endtask

    logic [W-1:0] exp_sum;

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_chain = '0;
        rsp_ready = 1'b1;

        // Reset state, with requests pending that must not be accepted
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_sum",   32'(rsp_sum),   32'h0);
        check("rst_rsp_cout",  32'(rsp_cout),  32'h0);
        check("rst_rsp_id",    32'(rsp_id),    32'h0);
        req_valid = '0;
        rst_n     = 1'b1;
        tick();

        // Single add on requester 2
        set_op(2, 16'h00FF, 16'h0001, 1'b0, 1'b0);
        req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        check("single_valid", 32'(rsp_valid), 32'h1);
        check("single_sum",   32'(rsp_sum),   32'h0100);
        check("single_cout",  32'(rsp_cout),  32'h0);
        check("single_id",    32'(rsp_id),    32'h2);

        // Overflow on requester 1, back-to-back; ptr=3 so scan is 3,0,1
        set_op(1, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
        req_valid = 4'b0010;
        #1;
        check("ovf_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        check("ovf_valid", 32'(rsp_valid), 32'h1);
        check("ovf_sum",   32'(rsp_sum),   32'h0001);
        check("ovf_cout",  32'(rsp_cout),  32'h1);
        check("ovf_id",    32'(rsp_id),    32'h1);
        tick();
        check("drain_valid", 32'(rsp_valid), 32'h0);

        // Fairness: reset ptr to 0, then all four valid continuously
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, W'(16'h1000 * (i + 1)), W'(i + 3), 1'b0, 1'b0);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("fair_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            check($sformatf("fair_valid_%0d", k), 32'(rsp_valid), 32'h1);
            check($sformatf("fair_id_%0d", k),    32'(rsp_id),    32'(k % 4));
            check($sformatf("fair_sum_%0d", k),   32'(rsp_sum),
                  32'(16'h1000 * ((k % 4) + 1) + (k % 4) + 3));
        end

        // Backpressure: result from requester 3 held, ptr now 0
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp_ready_%0d", k), 32'(req_ready), 32'h0);
            tick();
            check($sformatf("bp_valid_%0d", k), 32'(rsp_valid), 32'h1);
            check($sformatf("bp_id_%0d", k),    32'(rsp_id),    32'h3);
            check($sformatf("bp_sum_%0d", k),   32'(rsp_sum),   32'h4006);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("bp_new_id",  32'(rsp_id),  32'h0);
        check("bp_new_sum", 32'(rsp_sum), 32'h1003);
        tick();
        check("bp_drain_valid", 32'(rsp_valid), 32'h0);

        // Reset while FULL: requester 2 fills the slot (ptr=1 -> 3 afterwards)
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        check("mid_full", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_id",    32'(rsp_id),    32'h0);
        check("mid_rst_sum",   32'(rsp_sum),   32'h0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        #1;
        check("mid_first_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b1000;
        check("mid_first_id", 32'(rsp_id), 32'h1);
        tick();
        req_valid = '0;
        check("mid_second_id", 32'(rsp_id), 32'h3);

        // Carry chaining on requester 0
        set_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        req_valid = 4'b0001;
        tick();
        check("chain_lo_sum",  32'(rsp_sum),  32'h0000);
        check("chain_lo_cout", 32'(rsp_cout), 32'h1);
        set_op(0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        #1;
        check("chain_hi_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
`ifdef RCA_SCHED_CARRY_CHAIN_EN
        exp_sum = 16'h0001;
`else
        exp_sum = 16'h0000;
`endif
        check("chain_hi_sum", 32'(rsp_sum), 32'(exp_sum));
        check("chain_hi_id",  32'(rsp_id),  32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
